// File: rtl/ifetch.sv
// Instruction fetch: 32-bit PC, one registered instruction slot, optional jump-to-self halt (IFETCH_HALT_DETECT_EN).
// Latency: instruction visible one cycle after its address is driven; one instruction per cycle sustained.
// Backpressure: inst_ready low holds pc and the output register; redirect overrides and drops the slot.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [0:0]  state_q, state_d;

  logic        transfer;
  logic        load_en;
  logic        is_self_jump;
  logic        unused_redirect_lsbs;

  assign transfer = inst_valid_q && inst_ready;
  assign load_en  = (state_q == ST_RUN) && (!inst_valid_q || inst_ready);

  // Target alignment drops the low two bits of the redirect address.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef IFETCH_HALT_DETECT_EN
  // A J-format word whose low target bits equal the word index of its own pc jumps to itself.
  assign is_self_jump = (imem_rdata[31:26] == 6'b000010) && (imem_rdata[3:0] == pc_q[5:2]);
`else
  assign is_self_jump = 1'b0;
`endif

  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    state_d      = state_q;

    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      inst_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else if (load_en) begin
      inst_d       = imem_rdata;
      inst_pc_d    = pc_q;
      inst_valid_d = 1'b1;
      pc_d         = pc_q + 32'd4;
      if (is_self_jump) begin
        state_d = ST_HALT;
      end
    end else if ((state_q == ST_HALT) && transfer) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0000;
      inst_pc_q    <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      state_q      <= state_d;
    end
  end

  assign imem_addr  = pc_q[5:0];
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = (state_q == ST_HALT);

endmodule
